// File: rtl/wb_counter_ctrl_if.sv
// Wishbone slave bus bundle for wb_counter_ctrl.
//   master modport: drives strobe/cycle/write-enable/selects/address/write data,
//                   observes ack and read data.
//   slave modport : the opposite view, used by the counter block.
interface wb_counter_ctrl_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_counter_ctrl.sv
// Wishbone-controlled up/down counter with sticky compare-match interrupt.
// Ports:
//   wb_clk_i   - clock, all state on rising edge
//   wb_rst_ni  - synchronous active-low reset
//   wb         - Wishbone slave bus (stb/cyc/we/sel/adr/dat in, ack/dat out)
//   la_load_i  - logic-analyzer load strobe, level sensitive, top priority
//   la_data_i  - logic-analyzer load value
//   count_o    - current counter value (registered)
//   irq_o      - MATCH & IRQ_EN (registered)
// Register map on adr[3:2]: 0 CTRL{IRQ_EN,DIR,EN}, 1 COUNT, 2 CMP, 3 STATUS{MATCH}.
module wb_counter_ctrl #(
  parameter int unsigned BITS = 16
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  wb_counter_ctrl_if.slave    wb,
  input  logic                la_load_i,
  input  logic [BITS-1:0]     la_data_i,
  output logic [BITS-1:0]     count_o,
  output logic                irq_o
);

  localparam int unsigned DW     = 32;
  localparam int unsigned CTRL_W = 3;
  localparam int unsigned EN_B   = 0;
  localparam int unsigned DIR_B  = 1;
  localparam int unsigned IRQ_B  = 2;

  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_COUNT  = 2'd1,
    REG_CMP    = 2'd2,
    REG_STATUS = 2'd3
  } reg_addr_e;

  // State
  logic [CTRL_W-1:0] ctrl_q,  ctrl_nxt;
  logic [BITS-1:0]   count_q, count_nxt;
  logic [BITS-1:0]   cmp_q,   cmp_nxt;
  logic              match_q, match_nxt;
  logic              irq_q,   irq_nxt;
  logic              ack_q,   ack_nxt;
  logic [DW-1:0]     dat_q,   dat_nxt;

  // Bus decode
  logic          valid;
  logic          commit;
  logic          wr_commit;
  reg_addr_e     addr;
  logic [DW-1:0] wmask;
  logic [DW-1:0] rdata;
  logic          unused_adr;

  // Address bits outside [3:2] are intentionally ignored.
  assign unused_adr = ^{wb.wbs_adr_i[31:4], wb.wbs_adr_i[1:0]};

  // A transfer commits on the edge that raises ack; ack never repeats back-to-back.
  assign valid     = wb.wbs_cyc_i & wb.wbs_stb_i;
  assign commit    = valid & ~ack_q;
  assign wr_commit = commit & wb.wbs_we_i;
  assign addr      = reg_addr_e'(wb.wbs_adr_i[3:2]);

  // Expand byte lane selects into a bit mask.
  always_comb begin
    wmask = '0;
    for (int i = 0; i < 4; i++) begin
      wmask[8*i +: 8] = {8{wb.wbs_sel_i[i]}};
    end
  end

  // Read mux; unimplemented bits read as zero via zero extension.
  always_comb begin
    rdata = '0;
    case (addr)
      REG_CTRL:   rdata = DW'(ctrl_q);
      REG_COUNT:  rdata = DW'(count_q);
      REG_CMP:    rdata = DW'(cmp_q);
      REG_STATUS: rdata = DW'(match_q);
      default:    rdata = '0;
    endcase
  end

  // Next-state logic for registers, counter, match and bus response.
  always_comb begin
    ctrl_nxt  = ctrl_q;
    count_nxt = count_q;
    cmp_nxt   = cmp_q;
    match_nxt = match_q;
    ack_nxt   = commit;
    dat_nxt   = '0;

    if (commit && !wb.wbs_we_i) begin
      dat_nxt = rdata;
    end

    if (wr_commit && addr == REG_CTRL) begin
      ctrl_nxt = (ctrl_q & ~wmask[CTRL_W-1:0]) | (wb.wbs_dat_i[CTRL_W-1:0] & wmask[CTRL_W-1:0]);
    end

    if (wr_commit && addr == REG_CMP) begin
      cmp_nxt = BITS'((DW'(cmp_q) & ~wmask) | (wb.wbs_dat_i & wmask));
    end

    // Counter priority: LA load, bus write, count, hold.
    if (la_load_i) begin
      count_nxt = la_data_i;
    end else if (wr_commit && addr == REG_COUNT) begin
      count_nxt = BITS'((DW'(count_q) & ~wmask) | (wb.wbs_dat_i & wmask));
    end else if (ctrl_q[EN_B]) begin
      count_nxt = ctrl_q[DIR_B] ? (count_q - BITS'(1)) : (count_q + BITS'(1));
    end

    // Write-1-to-clear on lane 0; a same-cycle match set wins over the clear.
    if (wr_commit && addr == REG_STATUS && wb.wbs_sel_i[0] && wb.wbs_dat_i[0]) begin
      match_nxt = 1'b0;
    end
    if (ctrl_q[EN_B] && (count_q == cmp_q)) begin
      match_nxt = 1'b1;
    end

    // IRQ tracks the registered MATCH and IRQ_EN values exactly.
    irq_nxt = match_nxt & ctrl_nxt[IRQ_B];
  end

  // State registers with synchronous reset.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      ctrl_q  <= '0;
      count_q <= '0;
      cmp_q   <= '1;
      match_q <= 1'b0;
      irq_q   <= 1'b0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      ctrl_q  <= ctrl_nxt;
      count_q <= count_nxt;
      cmp_q   <= cmp_nxt;
      match_q <= match_nxt;
      irq_q   <= irq_nxt;
      ack_q   <= ack_nxt;
      dat_q   <= dat_nxt;
    end
  end

  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = dat_q;
  assign count_o      = count_q;
  assign irq_o        = irq_q;

endmodule

// File: tb/tb_wb_counter_ctrl.sv
// Directed bench for wb_counter_ctrl.
module tb_wb_counter_ctrl;
  localparam int unsigned BITS = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            la_load;
  logic [BITS-1:0] la_data;
  logic [BITS-1:0] count;
  logic            irq;

  int total = 0;
  int bad   = 0;

  wb_counter_ctrl_if wb ();

  wb_counter_ctrl #(.BITS(BITS)) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .wb        (wb),
    .la_load_i (la_load),
    .la_data_i (la_data),
    .count_o   (count),
    .irq_o     (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
    wb.wbs_sel_i = 4'h0;
    wb.wbs_adr_i = 32'h0;
    wb.wbs_dat_i = 32'h0;
  endtask

  task automatic wb_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] sel, input string tag);
    @(negedge clk);
    check({tag, "_pre_ack"}, 32'(wb.wbs_ack_o), 32'h0);
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_we_i  = 1'b1;
    wb.wbs_sel_i = sel;
    wb.wbs_adr_i = {28'h0, a, 2'b00};
    wb.wbs_dat_i = d;
    @(posedge clk);
    #1;
    check({tag, "_ack"}, 32'(wb.wbs_ack_o), 32'h1);
    @(negedge clk);
    bus_idle();
  endtask

  task automatic wb_read(input logic [1:0] a, input logic [31:0] exp, input string tag);
    @(negedge clk);
    check({tag, "_pre_ack"}, 32'(wb.wbs_ack_o), 32'h0);
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_we_i  = 1'b0;
    wb.wbs_sel_i = 4'hF;
    wb.wbs_adr_i = {28'h0, a, 2'b00};
    @(posedge clk);
    #1;
    check({tag, "_ack"}, 32'(wb.wbs_ack_o), 32'h1);
    check(tag, wb.wbs_dat_o, exp);
    @(negedge clk);
    bus_idle();
  endtask

  initial begin
    rst_n   = 1'b0;
    la_load = 1'b0;
    la_data = '0;
    bus_idle();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", 32'(wb.wbs_ack_o), 32'h0);
    check("rst_dat", wb.wbs_dat_o, 32'h0);
    check("rst_count", 32'(count), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    wb_read(2'd0, 32'h0, "rd_ctrl_rst");
    wb_read(2'd1, 32'h0, "rd_count_rst");
    wb_read(2'd2, 32'h0000FFFF, "rd_cmp_rst");
    wb_read(2'd3, 32'h0, "rd_status_rst");

    // Bits beyond BITS / undefined bits read zero
    wb_write(2'd2, 32'hABCD1234, 4'hF, "wr_cmp_wide");
    wb_read(2'd2, 32'h00001234, "rd_cmp_wide");
    wb_write(2'd0, 32'h000000F8, 4'hF, "wr_ctrl_undef");
    wb_read(2'd0, 32'h0, "rd_ctrl_undef");

    // Count up to compare value, match and irq
    wb_write(2'd2, 32'h5, 4'hF, "wr_cmp5");
    wb_write(2'd0, 32'h5, 4'hF, "wr_ctrl_en");
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk);
      #1;
      check("up_count", 32'(count), 32'(i));
    end
    check("irq_before_match", 32'(irq), 32'h0);
    @(posedge clk);
    #1;
    check("count_past_cmp", 32'(count), 32'h6);
    check("irq_on_match", 32'(irq), 32'h1);
    wb_write(2'd0, 32'h4, 4'hF, "wr_ctrl_stop");
    wb_read(2'd1, 32'h7, "rd_count_stopped");
    wb_read(2'd3, 32'h1, "rd_status_match");
    check("irq_sticky", 32'(irq), 32'h1);
    wb_write(2'd3, 32'h1, 4'hF, "wr_status_clr");
    check("irq_cleared", 32'(irq), 32'h0);
    wb_read(2'd3, 32'h0, "rd_status_cleared");

    // Byte-lane write, wrap up, wrap down
    wb_write(2'd1, 32'hFFFE, 4'b0001, "wr_count_lane0");
    wb_read(2'd1, 32'h00FE, "rd_count_lane0");
    wb_write(2'd1, 32'hFFFE, 4'hF, "wr_count_full");
    wb_read(2'd1, 32'hFFFE, "rd_count_full");
    wb_write(2'd0, 32'h1, 4'hF, "wr_ctrl_up");
    check("wrap_fffe", 32'(count), 32'hFFFE);
    @(posedge clk);
    #1;
    check("wrap_ffff", 32'(count), 32'hFFFF);
    @(posedge clk);
    #1;
    check("wrap_0000", 32'(count), 32'h0000);
    wb_write(2'd0, 32'h0, 4'hF, "wr_ctrl_off1");
    wb_write(2'd1, 32'h0, 4'hF, "wr_count_zero");
    wb_write(2'd0, 32'h3, 4'hF, "wr_ctrl_down");
    check("down_start", 32'(count), 32'h0);
    @(posedge clk);
    #1;
    check("down_wrap", 32'(count), 32'hFFFF);
    @(posedge clk);
    #1;
    check("down_fffe", 32'(count), 32'hFFFE);
    wb_write(2'd0, 32'h0, 4'hF, "wr_ctrl_off2");
    wb_read(2'd1, 32'hFFFD, "rd_count_down");

    // LA load overrides bus write and counting
    @(negedge clk);
    la_load = 1'b1;
    la_data = 16'h1234;
    wb_write(2'd1, 32'h0055, 4'hF, "wr_count_vs_la");
    check("la_hold_wr", 32'(count), 32'h1234);
    wb_write(2'd0, 32'h1, 4'hF, "wr_ctrl_en_la");
    check("la_hold_en", 32'(count), 32'h1234);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("la_hold", 32'(count), 32'h1234);
    end
    @(negedge clk);
    la_load = 1'b0;
    @(posedge clk);
    #1;
    check("la_release1", 32'(count), 32'h1235);
    @(posedge clk);
    #1;
    check("la_release2", 32'(count), 32'h1236);
    wb_write(2'd0, 32'h0, 4'hF, "wr_ctrl_off3");
    wb_read(2'd3, 32'h0, "rd_status_nomatch");

    // Persistent match beats write-1 clear; IRQ_EN masks without clearing
    @(negedge clk);
    la_load = 1'b1;
    la_data = 16'h0005;
    wb_write(2'd0, 32'h5, 4'hF, "wr_ctrl_en_irq");
    @(posedge clk);
    #1;
    check("irq_persist_match", 32'(irq), 32'h1);
    wb_write(2'd3, 32'h1, 4'hF, "wr_status_clr_busy");
    wb_read(2'd3, 32'h1, "rd_status_set_wins");
    check("irq_set_wins", 32'(irq), 32'h1);
    wb_write(2'd0, 32'h4, 4'hF, "wr_ctrl_irq_only");
    check("irq_en_only", 32'(irq), 32'h1);
    wb_write(2'd0, 32'h0, 4'hF, "wr_ctrl_mask");
    check("irq_masked", 32'(irq), 32'h0);
    wb_read(2'd3, 32'h1, "rd_status_masked");
    wb_write(2'd0, 32'h4, 4'hF, "wr_ctrl_unmask");
    check("irq_unmasked", 32'(irq), 32'h1);
    wb_write(2'd3, 32'h1, 4'hF, "wr_status_clr_idle");
    check("irq_after_clr", 32'(irq), 32'h0);
    wb_read(2'd3, 32'h0, "rd_status_clr_idle");
    @(negedge clk);
    la_load = 1'b0;

    // Reset between strobe and ack drops the write
    @(negedge clk);
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_we_i  = 1'b1;
    wb.wbs_sel_i = 4'hF;
    wb.wbs_adr_i = 32'h8;
    wb.wbs_dat_i = 32'h1234;
    rst_n        = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_ack", 32'(wb.wbs_ack_o), 32'h0);
    check("midrst_count", 32'(count), 32'h0);
    check("midrst_irq", 32'(irq), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus_idle();
    @(posedge clk);
    #1;
    check("midrst_ack_after", 32'(wb.wbs_ack_o), 32'h0);
    wb_read(2'd2, 32'h0000FFFF, "rd_cmp_after_rst");
    wb_read(2'd0, 32'h0, "rd_ctrl_after_rst");
    check("count_after_rst", 32'(count), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_counter_ctrl.md
Name: wb_counter_ctrl

Overview:
- Wishbone-controlled up/down counter with compare-match interrupt.
- Produces the count bus and the IRQ that the user-project top routes to io_out, la_data_out and irq.
- Sits directly downstream of the Wishbone MI A slave port.
- Also accepts a logic-analyzer load path so the management SoC can preset the count without bus traffic.

Parameters:
- BITS, 16: counter, compare and LA-load width (1..32).

Ports:
- wb_clk_i  input  1  system clock; all logic on rising edge
- wb_rst_ni  input  1  synchronous, active-low reset
- wbs_stb_i  input  1  Wishbone strobe
- wbs_cyc_i  input  1  Wishbone cycle
- wbs_we_i  input  1  write enable
- wbs_sel_i  input  4  byte lane selects
- wbs_adr_i  input  32  address; only [3:2] decoded
- wbs_dat_i  input  32  write data
- wbs_ack_o  output  1  transfer acknowledge
- wbs_dat_o  output  32  read data
- la_load_i  input  1  LA load strobe (level; loads every cycle while high)
- la_data_i  input  BITS  LA load value
- count_o  output  BITS  current counter value
- irq_o  output  1  compare-match interrupt

Behaviour:
- Reset: wb_rst_ni low at a clock edge clears state as follows.
  - CTRL=0, COUNT=0, CMP=all ones, STATUS=0.
  - wbs_ack_o=0, wbs_dat_o=0, count_o=0, irq_o=0.
  - Reset low mid-transfer drops any pending ack; the transfer is lost and the master must retry.
- Register map (wbs_adr_i[3:2]). Bits beyond BITS and undefined bits read 0 and ignore writes.
  - 0 CTRL: bit0 EN, bit1 DIR (0 up, 1 down), bit2 IRQ_EN.
  - 1 COUNT: R/W.
  - 2 CMP: R/W.
  - 3 STATUS: bit0 MATCH, sticky; write 1 clears, write 0 has no effect.
- Handshake:
  - valid = cyc & stb.
  - wbs_ack_o <= valid & ~wbs_ack_o. Ack arrives one cycle after valid, lasts exactly one cycle, and is never asserted on consecutive cycles.
  - A write commits on the edge where ack is set. Lanes are gated per byte by wbs_sel_i.
  - Read data is registered and valid in the ack cycle; wbs_dat_o is 0 whenever ack is low.
  - valid dropped before ack: no ack is issued and nothing is written.
- Counter update each cycle, highest priority first:
  1. la_load_i=1 -> COUNT <= la_data_i.
  2. Committing Wishbone write to COUNT -> byte-merged write value.
  3. EN=1 -> COUNT ± 1 per DIR, modulo 2^BITS (all ones +1 -> 0; 0 -1 -> all ones).
  4. Otherwise hold.
- Counting:
  - count_o = COUNT register; no combinational path from inputs.
  - A CTRL write setting EN takes effect from the following cycle's update.
- Match:
  - When EN=1 and COUNT==CMP, MATCH is set on the next edge.
  - Set takes priority over a simultaneous write-1 clear.
  - A COUNT or CMP write that creates equality sets MATCH the cycle after it commits, if EN=1.
- Interrupt:
  - irq_o = MATCH & IRQ_EN, registered alongside MATCH.
  - Clearing IRQ_EN masks irq_o next cycle without clearing MATCH.
- Read of COUNT in the same ack cycle as an increment returns the pre-increment value.

Test Plan:
- Reset then read all 4 registers -> CTRL=0, COUNT=0, CMP=0x0000FFFF, STATUS=0. Each read acks exactly 1 cycle after stb.
- Write CMP=5, CTRL=0x5 (EN, IRQ_EN, up) -> count_o steps 1,2,..5 one per cycle after EN. MATCH and irq_o rise the cycle after count_o==5. Count continues to 6.
- Write COUNT=0xFFFE with sel=4'b0001 -> only low byte written, COUNT=0x00FE. Then write full 0xFFFE, EN up -> count_o 0xFFFE, 0xFFFF, 0x0000 (wrap). DIR=1 from 0 -> 0xFFFF.
- Hold la_load_i=1, la_data_i=0x1234 while writing COUNT=0x0055 and EN=1 -> count_o stays 0x1234 every cycle. Release -> increments from 0x1234.
- MATCH set with EN: write STATUS=1 while COUNT==CMP persists -> MATCH remains 1. Disable EN, write STATUS=1 -> MATCH=0, irq_o=0 next cycle.
- Assert wb_rst_ni=0 for one cycle between stb and ack of a write to CMP -> no ack, CMP reads 0x0000FFFF afterward, count_o=0.
